cache_metadata_store: RTL and testbench

//   Per-set storage for L1 cache metadata {valid[3:0], dirty[3:0], plru[2:0]}.

---
 rtl/cache_metadata_store.sv | 105 ++++++++++
 tb/tb_cache_metadata_store.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cache_metadata_store.sv
// Per-set L1 metadata store {valid, dirty, plru} with a registered read port,
// a write port, and an init walk that zeroes every set after reset or invalidate-all.
module cache_metadata_store #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned META_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [META_W-1:0] wr_meta,
  input  logic              inv_req,
  output logic [META_W-1:0] rd_meta,
  output logic              rd_valid,
  output logic              init_busy
);

  localparam int unsigned NUM_SETS = 1 << IDX_W;
  localparam logic [IDX_W-1:0] CNT_LAST = {IDX_W{1'b1}};

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic [META_W-1:0]   rd_meta_q, rd_meta_d;
  logic                rd_valid_q, rd_valid_d;
  logic                init_busy_q, init_busy_d;

  logic [META_W-1:0]   mem_q [NUM_SETS];
  logic                mem_we;
  logic [IDX_W-1:0]    mem_waddr;
  logic [META_W-1:0]   mem_wdata;

  // Next-state, read data and the single write port shared by walk and wr_en
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rd_meta_d   = rd_meta_q;
    rd_valid_d  = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = wr_idx;
    mem_wdata   = wr_meta;

    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = IDX_W'(clr_cnt_q + 1'b1);
        if (clr_cnt_q == CNT_LAST) begin
          state_d   = S_READY;
          clr_cnt_d = '0;
        end
      end
      S_READY: begin
        if (inv_req) begin
          state_d = S_INIT;
        end else begin
          if (rd_en) begin
            rd_valid_d = 1'b1;
            // Write-first bypass when reading the set being written
            rd_meta_d  = (wr_en && (wr_idx == rd_idx)) ? wr_meta : mem_q[rd_idx];
          end
          mem_we = wr_en;
        end
      end
      default: state_d = S_INIT;
    endcase

    init_busy_d = (state_d == S_INIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      clr_cnt_q   <= '0;
      rd_meta_q   <= '0;
      rd_valid_q  <= 1'b0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rd_meta_q   <= rd_meta_d;
      rd_valid_q  <= rd_valid_d;
      init_busy_q <= init_busy_d;
    end
  end

  // Array is not reset; the init walk clears it
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_meta   = rd_meta_q;
  assign rd_valid  = rd_valid_q;
  assign init_busy = init_busy_q;

endmodule

// File: tb/tb_cache_metadata_store.sv
// Self-checking bench for cache_metadata_store: directed table, corner-case
// sequences and randomized traffic against an array-based reference model.
module tb_cache_metadata_store;

  logic        clk;
  logic        rst_n;
  logic        rd_en;
  logic [5:0]  rd_idx;
  logic        wr_en;
  logic [5:0]  wr_idx;
  logic [10:0] wr_meta;
  logic        inv_req;
  logic [10:0] rd_meta;
  logic        rd_valid;
  logic        init_busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [10:0] m_mem [64];
  int          m_busy;
  logic        m_valid;
  logic [10:0] m_meta;

  cache_metadata_store dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .rd_idx    (rd_idx),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_meta   (wr_meta),
    .inv_req   (inv_req),
    .rd_meta   (rd_meta),
    .rd_valid  (rd_valid),
    .init_busy (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic [5:0]  ri;
    logic        we;
    logic [5:0]  wi;
    logic [10:0] wm;
    logic        inv;
    logic        exp_valid;
    logic [10:0] exp_meta;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = 11'h000;
    m_busy  = 64;
    m_valid = 1'b0;
    m_meta  = 11'h000;
  endtask

  // One clock: drive inputs, update the model on the edge, compare at negedge
  task automatic step(input logic re, input logic [5:0] ri, input logic we,
                      input logic [5:0] wi, input logic [10:0] wm, input logic inv);
    rd_en = re; rd_idx = ri; wr_en = we; wr_idx = wi; wr_meta = wm; inv_req = inv;
    @(posedge clk);
    if (m_busy > 0) begin
      m_busy--;
      m_valid = 1'b0;
    end else if (inv) begin
      foreach (m_mem[i]) m_mem[i] = 11'h000;
      m_busy  = 64;
      m_valid = 1'b0;
    end else begin
      m_valid = re;
      if (re) m_meta = (we && wi == ri) ? wm : m_mem[ri];
      if (we) m_mem[wi] = wm;
    end
    @(negedge clk);
    chk("init_busy", 32'(init_busy), 32'(m_busy > 0));
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("rd_meta", 32'(rd_meta), 32'(m_meta));
  endtask

  task automatic idle();
    step(1'b0, 6'd0, 1'b0, 6'd0, 11'h000, 1'b0);
  endtask

  // Step until init_busy drops, returning how many edges that took
  task automatic count_busy(input logic re, output int n);
    n = 0;
    while (init_busy && n < 200) begin
      step(re, 6'd5, 1'b0, 6'd0, 11'h000, 1'b0);
      n++;
    end
  endtask

  vec_t vecs [14];
  int   nb;
  logic [5:0] ri, wi;

  initial begin
    vecs[0]  = '{1'b0, 6'd0,  1'b1, 6'd3,  11'h7A5, 1'b0, 1'b0, 11'h000};
    vecs[1]  = '{1'b1, 6'd3,  1'b0, 6'd0,  11'h000, 1'b0, 1'b1, 11'h7A5};
    vecs[2]  = '{1'b1, 6'd4,  1'b0, 6'd0,  11'h000, 1'b0, 1'b1, 11'h000};
    vecs[3]  = '{1'b1, 6'd9,  1'b1, 6'd9,  11'h3C1, 1'b0, 1'b1, 11'h3C1};
    vecs[4]  = '{1'b0, 6'd0,  1'b1, 6'd10, 11'h155, 1'b0, 1'b0, 11'h3C1};
    vecs[5]  = '{1'b1, 6'd10, 1'b1, 6'd9,  11'h0FF, 1'b0, 1'b1, 11'h155};
    vecs[6]  = '{1'b1, 6'd9,  1'b0, 6'd0,  11'h000, 1'b0, 1'b1, 11'h0FF};
    vecs[7]  = '{1'b0, 6'd0,  1'b1, 6'd0,  11'h111, 1'b0, 1'b0, 11'h0FF};
    vecs[8]  = '{1'b0, 6'd0,  1'b1, 6'd1,  11'h222, 1'b0, 1'b0, 11'h0FF};
    vecs[9]  = '{1'b0, 6'd0,  1'b1, 6'd2,  11'h333, 1'b0, 1'b0, 11'h0FF};
    vecs[10] = '{1'b1, 6'd0,  1'b0, 6'd0,  11'h000, 1'b0, 1'b1, 11'h111};
    vecs[11] = '{1'b1, 6'd1,  1'b0, 6'd0,  11'h000, 1'b0, 1'b1, 11'h222};
    vecs[12] = '{1'b1, 6'd2,  1'b0, 6'd0,  11'h000, 1'b0, 1'b1, 11'h333};
    vecs[13] = '{1'b0, 6'd0,  1'b0, 6'd0,  11'h000, 1'b0, 1'b0, 11'h333};

    rst_n = 1'b0; rd_en = 1'b0; rd_idx = '0; wr_en = 1'b0; wr_idx = '0;
    wr_meta = '0; inv_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(init_busy), 32'd1);
    chk("reset_valid", 32'(rd_valid), 32'd0);
    chk("reset_meta", 32'(rd_meta), 32'd0);

    // Walk after reset with rd_en held high
    rst_n = 1'b1;
    count_busy(1'b1, nb);
    chk("busy_len_reset", 32'(nb), 32'd64);
    step(1'b1, 6'd5, 1'b0, 6'd0, 11'h000, 1'b0);
    chk("rd_set5_valid", 32'(rd_valid), 32'd1);
    chk("rd_set5_meta", 32'(rd_meta), 32'h000);

    // Directed table
    foreach (vecs[k]) begin
      step(vecs[k].re, vecs[k].ri, vecs[k].we, vecs[k].wi, vecs[k].wm, vecs[k].inv);
      chk($sformatf("vec%0d_valid", k), 32'(rd_valid), 32'(vecs[k].exp_valid));
      chk($sformatf("vec%0d_meta", k), 32'(rd_meta), 32'(vecs[k].exp_meta));
    end

    // Fill, then invalidate with a colliding write that must be dropped
    for (int i = 0; i < 64; i++) step(1'b0, 6'd0, 1'b1, 6'(i), 11'h400 | 11'(i), 1'b0);
    step(1'b1, 6'd7, 1'b0, 6'd0, 11'h000, 1'b0);
    chk("prefill_rd7", 32'(rd_meta), 32'h407);
    step(1'b1, 6'd1, 1'b1, 6'd1, 11'h7FF, 1'b1);
    chk("inv_rd_dropped", 32'(rd_valid), 32'd0);
    count_busy(1'b0, nb);
    chk("busy_len_inv", 32'(nb), 32'd64);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 6'(i), 1'b0, 6'd0, 11'h000, 1'b0);
      chk($sformatf("inv_clear_set%0d", i), 32'(rd_meta), 32'h000);
    end

    // Reset in the middle of a walk
    step(1'b0, 6'd0, 1'b1, 6'd7, 11'h5A5, 1'b0);
    step(1'b1, 6'd7, 1'b0, 6'd0, 11'h000, 1'b0);
    chk("pre_rst_meta", 32'(rd_meta), 32'h5A5);
    step(1'b0, 6'd0, 1'b0, 6'd0, 11'h000, 1'b1);
    repeat (20) idle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midwalk_rst_busy", 32'(init_busy), 32'd1);
    chk("midwalk_rst_valid", 32'(rd_valid), 32'd0);
    chk("midwalk_rst_meta", 32'(rd_meta), 32'h000);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(1'b0, nb);
    chk("busy_len_rst", 32'(nb), 32'd64);
    for (int i = 0; i < 64; i++) step(1'b1, 6'(i), 1'b0, 6'd0, 11'h000, 1'b0);

    // Randomized traffic with occasional invalidate-all
    for (int n = 0; n < 3000; n++) begin
      wi = 6'($urandom_range(0, 63));
      ri = ($urandom_range(0, 3) == 0) ? wi : 6'($urandom_range(0, 63));
      step(1'($urandom), ri, 1'($urandom), wi, 11'($urandom),
           ($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
